// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle floating-point adder/subtractor.
// Operands are latched on start_i and walked through PREP, ALIGN (one bit
// per cycle), ADD, NORM (one bit per cycle), ROUND and DONE. Subnormals are
// treated as zero. Optional round-to-nearest-even, with overflow, underflow
// and inexact flags held alongside the result.
module fp_add_seq #(
  parameter  int EXP_W = 5,
  parameter  int MAN_W = 10,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         rnd_en_i,
  output logic [W-1:0] result_o,
  output logic         done_o,
  output logic         busy_o,
  output logic         ovf_o,
  output logic         unf_o,
  output logic         inexact_o
);

  // The alignment counter must hold both the exponent gap and the shift cap.
  localparam int CLOG_CAP = $clog2(MAN_W + 4);
  localparam int CNT_W    = ((EXP_W > CLOG_CAP) ? EXP_W : CLOG_CAP) + 1;
  localparam logic [CNT_W-1:0] CAP       = CNT_W'(MAN_W + 3);
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [MAN_W-1:0] QNAN_FRAC = MAN_W'(1) << (MAN_W - 1);
  localparam logic [EXP_W:0]   EXP_ONE   = (EXP_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     a_r, b_r;
  logic             rnd_r;
  logic             sa, sb;
  logic [EXP_W:0]   er;
  logic [MAN_W:0]   ma, mb;
  logic [MAN_W+1:0] sum;
  logic             g, r, s;
  logic [CNT_W-1:0] d, cnt;

  // Round-to-nearest-even increment decision.
  function automatic logic rne_inc(input logic en, input logic lsb,
                                   input logic gb, input logic rb, input logic sbit);
    return en & gb & (rb | sbit | lsb);
  endfunction

  // Signed infinity encoding.
  function automatic logic [W-1:0] inf_of(input logic sign);
    return {sign, EXP_ONES, {MAN_W{1'b0}}};
  endfunction

  // Operand unpacking, classification and magnitude ordering.
  logic [EXP_W-1:0] ea_u, eb_u, e_big, e_sml, e_diff;
  logic [MAN_W-1:0] fa_u, fb_u, f_big, f_sml;
  logic             s_big, s_sml, a_big, a_inf, b_inf, a_zero, b_zero;
  always_comb begin
    ea_u   = a_r[W-2:MAN_W];
    eb_u   = b_r[W-2:MAN_W];
    fa_u   = a_r[MAN_W-1:0];
    fb_u   = b_r[MAN_W-1:0];
    a_inf  = (ea_u == EXP_ONES);
    b_inf  = (eb_u == EXP_ONES);
    a_zero = (ea_u == '0);
    b_zero = (eb_u == '0);
    a_big  = ({ea_u, fa_u} >= {eb_u, fb_u});
    e_big  = a_big ? ea_u : eb_u;
    e_sml  = a_big ? eb_u : ea_u;
    f_big  = a_big ? fa_u : fb_u;
    f_sml  = a_big ? fb_u : fa_u;
    s_big  = a_big ? a_r[W-1] : b_r[W-1];
    s_sml  = a_big ? b_r[W-1] : a_r[W-1];
    e_diff = e_big - e_sml;
  end

  // Datapath arithmetic for ALIGN, ADD and ROUND.
  logic [MAN_W:0]   mb_sh;
  logic [CNT_W-1:0] cnt_nx;
  logic [MAN_W+1:0] add_sum;
  logic [MAN_W+3:0] sub_dif;
  logic             inc;
  logic [MAN_W:0]   frac_inc;
  logic [EXP_W:0]   rnd_e;
  always_comb begin
    mb_sh    = mb >> 1;
    cnt_nx   = cnt + 1'b1;
    add_sum  = {1'b0, ma} + {1'b0, mb};
    sub_dif  = {ma, 3'b000} - {mb, g, r, s};
    inc      = rne_inc(rnd_r, sum[0], g, r, s);
    // A carry out of the fraction leaves the low bits at zero by construction.
    frac_inc = {1'b0, sum[MAN_W-1:0]} + {{MAN_W{1'b0}}, inc};
    rnd_e    = er + {{EXP_W{1'b0}}, frac_inc[MAN_W]};
  end

  // Control FSM with registered outputs; reset aborts any operation at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      result_o  <= '0;
      done_o    <= 1'b0;
      busy_o    <= 1'b0;
      ovf_o     <= 1'b0;
      unf_o     <= 1'b0;
      inexact_o <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      rnd_r     <= 1'b0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      er        <= '0;
      ma        <= '0;
      mb        <= '0;
      sum       <= '0;
      g         <= 1'b0;
      r         <= 1'b0;
      s         <= 1'b0;
      d         <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE) done_o <= 1'b1;
          if (start_i) begin
            a_r       <= a_i;
            b_r       <= b_i;
            rnd_r     <= rnd_en_i;
            done_o    <= 1'b0;
            ovf_o     <= 1'b0;
            unf_o     <= 1'b0;
            inexact_o <= 1'b0;
            busy_o    <= 1'b1;
            state     <= S_PREP;
          end
        end

        S_PREP: begin
          if (a_inf || b_inf) begin
            if (a_inf && b_inf && (a_r[W-1] != b_r[W-1]))
              result_o <= {1'b0, EXP_ONES, QNAN_FRAC};
            else if (a_inf)
              result_o <= inf_of(a_r[W-1]);
            else
              result_o <= inf_of(b_r[W-1]);
            busy_o <= 1'b0;
            state  <= S_DONE;
          end else if (a_zero || b_zero) begin
            if (a_zero && b_zero)
              result_o <= {a_r[W-1] & b_r[W-1], {(W-1){1'b0}}};
            else if (a_zero)
              result_o <= b_r;
            else
              result_o <= a_r;
            busy_o <= 1'b0;
            state  <= S_DONE;
          end else begin
            sa    <= s_big;
            sb    <= s_sml;
            er    <= {1'b0, e_big};
            ma    <= {1'b1, f_big};
            mb    <= {1'b1, f_sml};
            g     <= 1'b0;
            r     <= 1'b0;
            s     <= 1'b0;
            cnt   <= '0;
            d     <= {{(CNT_W-EXP_W){1'b0}}, e_diff};
            state <= (e_diff != '0) ? S_ALIGN : S_ADD;
          end
        end

        S_ALIGN: begin
          cnt <= cnt_nx;
          g   <= mb[0];
          r   <= g;
          if (cnt_nx == CAP) begin
            mb    <= '0;
            s     <= s | r | (|mb_sh);
            state <= S_ADD;
          end else begin
            mb <= mb_sh;
            s  <= s | r;
            if (cnt_nx == d) state <= S_ADD;
          end
        end

        S_ADD: begin
          if (sa == sb) begin
            sum   <= add_sum;
            state <= (add_sum[MAN_W+1] || !add_sum[MAN_W]) ? S_NORM : S_ROUND;
          end else if (sub_dif == '0) begin
            result_o <= '0;
            busy_o   <= 1'b0;
            state    <= S_DONE;
          end else begin
            sum       <= {1'b0, sub_dif[MAN_W+3:3]};
            {g, r, s} <= sub_dif[2:0];
            state     <= sub_dif[MAN_W+3] ? S_ROUND : S_NORM;
          end
        end

        S_NORM: begin
          if (sum[MAN_W+1]) begin
            sum   <= sum >> 1;
            g     <= sum[0];
            r     <= g;
            s     <= s | r;
            er    <= er + 1'b1;
            state <= S_ROUND;
          end else if (er == EXP_ONE) begin
            result_o <= {sa, {(W-1){1'b0}}};
            unf_o    <= 1'b1;
            busy_o   <= 1'b0;
            state    <= S_DONE;
          end else begin
            sum <= {sum[MAN_W:0], g};
            g   <= r;
            r   <= s;
            er  <= er - 1'b1;
            if (sum[MAN_W-1]) state <= S_ROUND;
          end
        end

        S_ROUND: begin
          inexact_o <= g | r | s;
          if (rnd_e >= {1'b0, EXP_ONES}) begin
            result_o <= inf_of(sa);
            ovf_o    <= 1'b1;
          end else begin
            result_o <= {sa, rnd_e[EXP_W-1:0], frac_inc[MAN_W-1:0]};
          end
          busy_o <= 1'b0;
          state  <= S_DONE;
        end

        default: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq (half precision defaults): a vector table
// of operands with expected result, flags and latency, plus hand-written
// sequences for reset, a start ignored while busy, and reset mid-operation.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [15:0] a_i, b_i;
  logic        rnd_en_i;
  logic [15:0] result_o;
  logic        done_o, busy_o, ovf_o, unf_o, inexact_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_add_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .rnd_en_i  (rnd_en_i),
    .result_o  (result_o),
    .done_o    (done_o),
    .busy_o    (busy_o),
    .ovf_o     (ovf_o),
    .unf_o     (unf_o),
    .inexact_o (inexact_o)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        rnd;
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
    int          lat;
  } vec_t;

  localparam int NV = 17;
  vec_t tv[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present operands with start_i for one rising edge; returns 1 ns after it.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic rnd);
    @(posedge clk);
    #1;
    a_i      = a;
    b_i      = b;
    rnd_en_i = rnd;
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i  = 1'b0;
  endtask

  // Count rising edges until done_o, bounded so a stuck design cannot hang.
  task automatic wait_done(inout int lat);
    while (!done_o && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;

    //         a        b        rnd   res      ovf   unf   inx   lat
    tv[0]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b0, 5};
    tv[1]  = '{16'h3C00, 16'hBC00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 3};
    tv[2]  = '{16'h4200, 16'hC100, 1'b1, 16'h3800, 1'b0, 1'b0, 1'b0, 6};
    tv[3]  = '{16'h3C00, 16'h1000, 1'b1, 16'h3C00, 1'b0, 1'b0, 1'b1, 15};
    tv[4]  = '{16'h3C01, 16'h1000, 1'b1, 16'h3C02, 1'b0, 1'b0, 1'b1, 15};
    tv[5]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C01, 1'b0, 1'b0, 1'b1, 15};
    tv[6]  = '{16'h7BFF, 16'h7BFF, 1'b1, 16'h7C00, 1'b1, 1'b0, 1'b0, 5};
    tv[7]  = '{16'h7C00, 16'h3C00, 1'b1, 16'h7C00, 1'b0, 1'b0, 1'b0, 2};
    tv[8]  = '{16'h7C00, 16'hFC00, 1'b1, 16'h7E00, 1'b0, 1'b0, 1'b0, 2};
    tv[9]  = '{16'h0000, 16'hC000, 1'b1, 16'hC000, 1'b0, 1'b0, 1'b0, 2};
    tv[10] = '{16'h7800, 16'h0400, 1'b1, 16'h7800, 1'b0, 1'b0, 1'b1, 17};
    tv[11] = '{16'h0500, 16'h8480, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 4};
    tv[12] = '{16'h1000, 16'h3C00, 1'b1, 16'h3C00, 1'b0, 1'b0, 1'b1, 15};
    tv[13] = '{16'h3C00, 16'hC000, 1'b1, 16'hBC00, 1'b0, 1'b0, 1'b0, 6};
    tv[14] = '{16'h3FFF, 16'h1000, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b1, 15};
    tv[15] = '{16'h8000, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 2};
    tv[16] = '{16'h8000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 2};

    reset    = 1'b1;
    start_i  = 1'b0;
    a_i      = '0;
    b_i      = '0;
    rnd_en_i = 1'b0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("rst result", 32'(result_o), 32'h0);
    chk("rst done", 32'(done_o), 32'h0);
    chk("rst busy", 32'(busy_o), 32'h0);
    chk("rst ovf", 32'(ovf_o), 32'h0);
    chk("rst unf", 32'(unf_o), 32'h0);
    chk("rst inexact", 32'(inexact_o), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      launch(tv[i].a, tv[i].b, tv[i].rnd);
      chk($sformatf("v%0d busy", i), 32'(busy_o), 32'h1);
      lat = 0;
      wait_done(lat);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(tv[i].lat));
      chk($sformatf("v%0d result", i), 32'(result_o), 32'(tv[i].res));
      chk($sformatf("v%0d ovf", i), 32'(ovf_o), 32'(tv[i].ovf));
      chk($sformatf("v%0d unf", i), 32'(unf_o), 32'(tv[i].unf));
      chk($sformatf("v%0d inexact", i), 32'(inexact_o), 32'(tv[i].inx));
      chk($sformatf("v%0d busy end", i), 32'(busy_o), 32'h0);
    end

    // A start pulse during ALIGN must be ignored
    launch(16'h3C00, 16'h1000, 1'b1);
    lat = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      lat++;
    end
    a_i     = 16'h7BFF;
    b_i     = 16'h7BFF;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start_i = 1'b0;
    wait_done(lat);
    chk("busy start latency", 32'(lat), 32'd15);
    chk("busy start result", 32'(result_o), 32'h3C00);
    chk("busy start ovf", 32'(ovf_o), 32'h0);
    chk("busy start inexact", 32'(inexact_o), 32'h1);

    // Reset asserted while in NORM clears outputs without waiting for a clock
    launch(16'h4200, 16'hC100, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    chk("norm busy", 32'(busy_o), 32'h1);
    reset = 1'b0;
    #1;
    chk("abort busy", 32'(busy_o), 32'h0);
    chk("abort done", 32'(done_o), 32'h0);
    chk("abort result", 32'(result_o), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // First start after reset behaves normally
    launch(16'h3C00, 16'h3C00, 1'b1);
    lat = 0;
    wait_done(lat);
    chk("post rst latency", 32'(lat), 32'd5);
    chk("post rst result", 32'(result_o), 32'h4000);
    chk("post rst inexact", 32'(inexact_o), 32'h0);

    // Result and done are held while idle in DONE
    repeat (4) @(posedge clk);
    #1;
    chk("hold result", 32'(result_o), 32'h4000);
    chk("hold done", 32'(done_o), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_add_seq.md
Name: fp_add_seq

Overview:
Parametrised multi-cycle floating-point adder/subtractor for the data-path program blocks. It is the successor to the fixed half-precision, add-only, no-round float adder. It adds configurable exponent and mantissa widths, opposite-sign (subtraction) handling, normalisation, selectable round-to-nearest-even, and exception flags. Operands are latched on a start pulse, and the result is held with a level done until the next start.

Parameters:
EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1
MAN_W, 10, stored fraction width; hidden bit implied
W, 1+EXP_W+MAN_W (derived, not overridable), operand/result word width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately)
start_i  input  1  request; sampled only in IDLE or DONE
a_i  input  W  operand A, {sign, exp, frac}
b_i  input  W  operand B
rnd_en_i  input  1  latched with operands; 1 = round-to-nearest-even, 0 = truncate (legacy mode)
result_o  output  W  sum, valid while done_o=1
done_o  output  1  level; high from DONE entry until next accepted start
busy_o  output  1  high in every state except IDLE/DONE
ovf_o  output  1  result saturated to infinity
unf_o  output  1  result flushed to zero on exponent underflow
inexact_o  output  1  any nonzero G/R/S bit discarded

Behaviour:
- Reset (reset=0): state=IDLE; result_o, done_o, busy_o, ovf_o, unf_o and inexact_o all 0.
- Start acceptance:
  - start_i=1 in IDLE or DONE latches a_i, b_i and rnd_en_i, clears done_o and all flags, and moves to PREP.
  - start_i is ignored while busy_o=1.
- PREP (1 cycle):
  - Unpack operands; an operand with exp==0 is zero (no subnormals; fraction ignored).
  - Specials (exp all-ones) go straight to DONE:
    - any operand inf gives inf with that operand's sign;
    - inf + opposite inf gives {0, all-ones exp, 1'b1, zeros}.
  - One operand zero: result = other operand, go to DONE.
  - Both operands zero: result is -0 only if both are negative, else +0; go to DONE.
  - Otherwise swap so that A has magnitude >= B ({exp,frac} compare).
  - d = expA-expB; next state is ALIGN if d>0, else ADD.
- ALIGN (one bit per cycle):
  - Each cycle: mantB >>= 1; S |= R; R = G; G = shifted-out bit.
  - Stops when the counter reaches d, or reaches MAN_W+3. At the cap the remaining mantB bits are ORed into S and mantB=0.
  - Cycle count = min(d, MAN_W+3).
- ADD (1 cycle):
  - Same sign: MAN_W+2-bit sum.
  - Different sign: mantA - mantB with borrow through {G,R,S}.
  - Exact zero difference: result = +0, go to DONE.
  - sign = signA; exp = expA.
- NORM:
  - If the carry bit is set: one cycle right shift (sticky updated), exp+1.
  - Else, while the hidden bit is 0: left shift one bit per cycle (G shifts in, R to G, S to R), exp-1.
  - If exp would reach 0: result = signed zero, unf_o=1, go to DONE.
  - An already-normalised value skips NORM and goes to ROUND.
- ROUND (1 cycle):
  - inexact_o = G|R|S.
  - If rnd_en_i, increment when G & (R|S|LSB).
  - Mantissa carry-out: frac=0, exp+1.
  - exp == all-ones after this step: result = signed inf, ovf_o=1.
- DONE:
  - result_o is registered and done_o=1, held until the next start.
  - Flags are held alongside result_o.
- Latency from the start edge (rounding enabled): 1+min(d,MAN_W+3)+1+n_norm+1+1 cycles.
- Reset mid-operation aborts immediately to the reset state; the first start after reset is accepted normally.

Test Plan:
- Carry normalisation: 0x3C00 + 0x3C00, start at cycle N -> result 0x4000, done_o rises at N+5 (PREP, ADD, NORM, ROUND, DONE), no flags.
- Cancellation: 0x3C00 + 0xBC00 -> 0x0000, done_o at N+3; 0x4200 + 0xC100 -> 0x3800 after 2 NORM cycles.
- Rounding: 0x3C00 + 0x1000 with rnd_en_i=1 -> 0x3C00 (tie to even), inexact_o=1, 11 ALIGN cycles; 0x3C01 + 0x1000 -> 0x3C02 with rnd_en_i=1 and 0x3C01 with rnd_en_i=0.
- Overflow/specials:
  - 0x7BFF + 0x7BFF -> 0x7C00, ovf_o=1.
  - 0x7C00 + 0x3C00 -> 0x7C00.
  - 0x7C00 + 0xFC00 -> 0x7E00.
  - 0x0000 + 0xC000 -> 0xC000 via PREP to DONE.
- Large exponent gap: 0x7800 + 0x0400 -> 0x7800, ALIGN capped at 13 cycles, inexact_o=1.
- Control: a second start_i during ALIGN is ignored and the first result is unchanged. Pulsing reset=0 in NORM clears busy_o/done_o/result_o within the same cycle. A start afterwards with 0x3C00 + 0x3C00 -> 0x4000.
